pwm_input_conditioner: RTL and testbench
========================================

Name: pwm_input_conditioner

Overview:
- Front-end stage that drives the pwm_in of the PWM frequency multiplier.
- Synchronises the raw external PWM pin into the clk domain and removes glitches with a consecutive-sample filter.
- Emits single-cycle rise and fall strobes.
- Flags loss of signal when no edge is seen within a window. The downstream 16-bit high/low measurement counters would wrap past that window.

Parameters:
- SYNC_STAGES, 2: flops in the input synchroniser chain (>=2).
- FILTER_LEN, 4: consecutive identical synchronised samples needed to accept a level change (>=1; 1 disables filtering).
- TIMEOUT_W, 16: width of the idle counter.
- TIMEOUT_CYCLES, 65535: idle cycles without a clean edge before signal_lost asserts (<= 2^TIMEOUT_W - 1).

Ports:
- clk  input  1  system clock, 100 MHz nominal, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- pwm_raw  input  1  asynchronous external PWM pin.
- pwm_clean  output  1  synchronised, filtered PWM; feeds the multiplier pwm_in.
- rise_pulse  output  1  one-cycle strobe on a clean 0->1 transition.
- fall_pulse  output  1  one-cycle strobe on a clean 1->0 transition.
- signal_lost  output  1  high while no clean edge has occurred for TIMEOUT_CYCLES cycles.
- stuck_level  output  1  level of pwm_clean captured when signal_lost asserted.
- glitch_count  output  8  saturating count of rejected glitches.

Behaviour:
- Reset is asynchronous and active-high. Every flop clears immediately, and all outputs read 0 while rst is high: sync chain, pwm_clean, filter counter, pulses, idle counter, signal_lost, stuck_level, glitch_count.
- Synchroniser: pwm_raw is shifted through SYNC_STAGES flops; the last stage is sync_out.
- Filter state is pwm_clean plus filt_cnt (clog2(FILTER_LEN)+1 bits).
  - If sync_out == pwm_clean: filt_cnt <= 0. If filt_cnt was nonzero, the event counts as a glitch.
  - Otherwise, if filt_cnt == FILTER_LEN-1: pwm_clean <= sync_out and filt_cnt <= 0. Otherwise filt_cnt <= filt_cnt+1.
- Latency: pwm_raw changes and stays stable before clock edge 1. pwm_clean takes the new value at edge SYNC_STAGES+FILTER_LEN (edge 6 with defaults).
- Any raw pulse shorter than FILTER_LEN cycles is absorbed. A pulse of exactly FILTER_LEN cycles propagates.
- rise_pulse / fall_pulse are registered and high for exactly the first cycle pwm_clean shows the new level. They are never high together.
- Idle counter:
  - Cleared to 0 at the edge where pwm_clean changes.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - signal_lost is registered and goes high at the edge where the count reaches TIMEOUT_CYCLES. stuck_level <= pwm_clean at that same edge.
  - signal_lost clears at the same edge that a rise or fall strobe asserts. stuck_level holds its value until the next assertion.
- After reset with a static input, signal_lost asserts TIMEOUT_CYCLES cycles after rst deasserts.
- glitch_count increments by 1 per glitch and saturates at 255. It is cleared only by reset.
- A new differing run that starts on the cycle right after a glitch reset starts counting from 0 again. No carry-over.

Optional Feature:
- Macro: PWM_COND_GLITCH_COUNT_EN.
- Defined: glitch detection and the 8-bit saturating glitch_count are present as described.
- Undefined: the glitch logic is not compiled. glitch_count is tied to 8'd0. The filter and all other outputs are unchanged.

Test Plan:
- Reset: hold rst=1 for 10 cycles with pwm_raw toggling -> all outputs 0. Release with pwm_raw=0 for 100 cycles -> pwm_clean=0 and no strobes.
- Clean edge: pwm_raw 0->1 held -> pwm_clean=1 at edge 6 and rise_pulse high for exactly that cycle. Later 1->0 -> fall_pulse at edge 6 after the change.
- Glitch: pwm_raw high for 3 cycles, then low -> pwm_clean stays 0, no rise_pulse, glitch_count=1 (macro on) or 0 (macro off). A 4-cycle pulse -> pwm_clean high for 4 cycles, one rise and one fall strobe.
- 1 kHz 50% input, 50000 cycles high / 50000 low for 4 periods -> 4 rise and 4 fall strobes spaced 100000 cycles apart, signal_lost never asserts.
- 75% input, 75000 high / 25000 low -> signal_lost rises 65535 cycles after the rise strobe with stuck_level=1. It clears on the fall_pulse cycle.
- Timeout and reset mid-operation: with TIMEOUT_CYCLES=100 and static pwm_raw=1 -> signal_lost at cycle 100 with stuck_level=1. Asserting rst mid-high-phase -> all outputs 0 immediately. After release, pwm_clean returns to 1 at edge 6.

Source files
------------

// File: rtl/pwm_input_conditioner.sv
// PWM input front end: synchroniser, consecutive-sample glitch filter, edge strobes and loss-of-signal timeout.
// Optional macro PWM_COND_GLITCH_COUNT_EN compiles in the saturating rejected-glitch counter.
module pwm_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_raw,
  output logic       pwm_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       signal_lost,
  output logic       stuck_level,
  output logic [7:0] glitch_count
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0]     FILT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] IDLE_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] IDLE_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       filt_cnt;
  logic [TIMEOUT_W-1:0]   idle_cnt;
  logic                   differs;
  logic                   accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_raw};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differs  = (sync_out != pwm_clean);
  assign accept   = differs && (filt_cnt == FILT_LAST);

  // A level change is taken only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_clean  <= 1'b0;
      filt_cnt   <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept && sync_out;
      fall_pulse <= accept && !sync_out;
      if (!differs || accept) begin
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
      if (accept) begin
        pwm_clean <= sync_out;
      end
    end
  end

  // Idle counter saturates; signal_lost is set on the edge that reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      signal_lost <= 1'b0;
      stuck_level <= 1'b0;
    end else if (accept) begin
      idle_cnt    <= '0;
      signal_lost <= 1'b0;
    end else begin
      if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (idle_cnt == IDLE_LAST) begin
        signal_lost <= 1'b1;
        stuck_level <= pwm_clean;
      end
    end
  end

`ifdef PWM_COND_GLITCH_COUNT_EN
  logic glitch;

  assign glitch = !differs && (filt_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_count <= 8'd0;
    end else if (glitch && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`else
  assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_pwm_input_conditioner.sv
// Bench for pwm_input_conditioner: directed phases plus random pulse trains checked every cycle
// against a sample-history reference model.
module tb_pwm_input_conditioner;

  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int TW   = 8;
  localparam int TO   = 200;
  localparam int LAT  = SYNC + FL;
`ifdef PWM_COND_GLITCH_COUNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_raw;
  logic       pwm_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       signal_lost;
  logic       stuck_level;
  logic [7:0] glitch_count;

  pwm_input_conditioner #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FL),
    .TIMEOUT_W     (TW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_raw     (pwm_raw),
    .pwm_clean   (pwm_clean),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .signal_lost (signal_lost),
    .stuck_level (stuck_level),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw delay line, recent filter samples, and time since last clean edge.
  bit m_pipe [SYNC];
  bit m_hist [FL];
  bit m_clean, m_rise, m_fall, m_lost, m_stuck;
  int m_idle, m_glitches;

  int cyc, rise_seen, fall_seen, lost_seen, clean_hi;
  int last_rise_cyc, lost_rise_cyc;
  bit prev_lost_obs;

  function automatic void modelReset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    for (int i = 0; i < FL; i++) m_hist[i] = 1'b0;
    m_clean = 0; m_rise = 0; m_fall = 0; m_lost = 0; m_stuck = 0;
    m_idle = 0; m_glitches = 0;
  endfunction

  function automatic void modelStep(bit raw);
    bit s, prev_differs, stable, lost_before;
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = raw;
    prev_differs = (m_hist[0] != m_clean);
    for (int i = FL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
    stable = 1'b1;
    for (int i = 0; i < FL; i++) if (m_hist[i] == m_clean) stable = 1'b0;
    m_rise = stable && s;
    m_fall = stable && !s;
    if (GLITCH_EN && !stable && (s == m_clean) && prev_differs && m_glitches < 255)
      m_glitches++;
    lost_before = m_lost;
    if (stable) begin
      m_clean = s;
      m_idle  = 0;
    end else if (m_idle < TO) begin
      m_idle++;
    end
    m_lost = (m_idle == TO);
    if (m_lost && !lost_before) m_stuck = m_clean;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ":pwm_clean"},    32'(pwm_clean),    32'(m_clean));
    checkValue({tag, ":rise_pulse"},   32'(rise_pulse),   32'(m_rise));
    checkValue({tag, ":fall_pulse"},   32'(fall_pulse),   32'(m_fall));
    checkValue({tag, ":signal_lost"},  32'(signal_lost),  32'(m_lost));
    checkValue({tag, ":stuck_level"},  32'(stuck_level),  32'(m_stuck));
    checkValue({tag, ":glitch_count"}, 32'(glitch_count), 32'(m_glitches));
    if (rise_pulse === 1'b1) begin rise_seen++; last_rise_cyc = cyc; end
    if (fall_pulse === 1'b1) fall_seen++;
    if (pwm_clean === 1'b1) clean_hi++;
    if (signal_lost === 1'b1) begin
      lost_seen++;
      if (!prev_lost_obs) lost_rise_cyc = cyc;
    end
    prev_lost_obs = (signal_lost === 1'b1);
  endtask

  task automatic applyStimulus(input bit level, input int cycles, input string tag);
    repeat (cycles) begin
      pwm_raw = level;
      @(posedge clk);
      cyc++;
      if (rst) modelReset();
      else modelStep(level);
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic measureLatency(input bit level, input string tag);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      applyStimulus(level, 1, tag);
      edges++;
      if (pwm_clean === level) seen = 1'b1;
    end
    checkValue({tag, ":latency"}, 32'(edges), 32'(LAT));
    checkValue({tag, ":strobe"}, 32'(level ? rise_pulse : fall_pulse), 32'd1);
  endtask

  task automatic clearTallies();
    rise_seen = 0; fall_seen = 0; lost_seen = 0; clean_hi = 0;
  endtask

  initial begin
    bit lvl;
    int len;
    cyc = 0; last_rise_cyc = 0; lost_rise_cyc = 0; prev_lost_obs = 1'b0;
    clearTallies();
    modelReset();
    rst     = 1'b1;
    pwm_raw = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(1'(i % 2), 1, "reset_hold");
    rst = 1'b0;
    applyStimulus(1'b0, 100, "idle_low");
    checkValue("idle_low:rises", 32'(rise_seen), 32'd0);

    measureLatency(1'b1, "clean_rise");
    applyStimulus(1'b1, 20, "hold_high");
    measureLatency(1'b0, "clean_fall");
    applyStimulus(1'b0, 20, "hold_low");

    clearTallies();
    applyStimulus(1'b1, 3, "glitch3");
    applyStimulus(1'b0, 20, "glitch3_after");
    checkValue("glitch3:count", 32'(glitch_count), GLITCH_EN ? 32'd1 : 32'd0);
    checkValue("glitch3:rises", 32'(rise_seen), 32'd0);

    clearTallies();
    applyStimulus(1'b1, 4, "pulse4");
    applyStimulus(1'b0, 20, "pulse4_after");
    checkValue("pulse4:rises", 32'(rise_seen), 32'd1);
    checkValue("pulse4:falls", 32'(fall_seen), 32'd1);
    checkValue("pulse4:high_cycles", 32'(clean_hi), 32'd4);

    clearTallies();
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b1, 150, "duty50_high");
      applyStimulus(1'b0, 150, "duty50_low");
    end
    checkValue("duty50:rises", 32'(rise_seen), 32'd4);
    checkValue("duty50:falls", 32'(fall_seen), 32'd4);
    checkValue("duty50:lost_cycles", 32'(lost_seen), 32'd0);

    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 300, "duty75_high");
      checkValue("duty75:lost_delay", 32'(lost_rise_cyc - last_rise_cyc), 32'(TO));
      checkValue("duty75:stuck", 32'(stuck_level), 32'd1);
      applyStimulus(1'b0, 100, "duty75_low");
      checkValue("duty75:lost_cleared", 32'(signal_lost), 32'd0);
    end

    applyStimulus(1'b1, 250, "static_high");
    checkValue("static_high:lost", 32'(signal_lost), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    applyStimulus(1'b1, 3, "reset_mid");
    rst = 1'b0;
    measureLatency(1'b1, "post_reset_rise");

    for (int i = 0; i < 1200; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 6));
      applyStimulus(lvl, len, "random");
    end
    applyStimulus(1'b0, 250, "static_low");
    checkValue("static_low:lost", 32'(signal_lost), 32'd1);
    checkValue("static_low:stuck", 32'(stuck_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
